// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero counter with valid/ready handshake, flush and tag passthrough.
// Define LZC_NORM_EN to also register the left-normalised operand on out_data (tied 0 otherwise).
module lzc_pipe #(
  parameter  int WIDTH = 128,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
    logic             zero;
  } res_t;

  logic [WIDTH-1:0]             lv, nv;
  logic [WIDTH-1:0][CNT_W-1:0]  lc, nc;
  logic                         tree_zero;
  logic [CNT_W-1:0]             tree_cnt;

  // Halving tree: each level merges (upper, lower) node pairs; a dead upper half
  // adds its width to the lower count.
  always_comb begin
    lv = in_data;
    lc = '0;
    nv = '0;
    nc = '0;
    for (int k = 1; k <= CNT_W; k++) begin
      nv = '0;
      nc = '0;
      for (int j = 0; j < (WIDTH >> k); j++) begin
        nv[j] = lv[2*j+1] | lv[2*j];
        nc[j] = lv[2*j+1] ? lc[2*j+1] : (lc[2*j] | CNT_W'(1 << (k-1)));
      end
      lv = nv;
      lc = nc;
    end
    tree_zero = ~lv[0];
    tree_cnt  = lv[0] ? lc[0] : '0;
  end

  logic [2:1] vld_pipe_q, vld_pipe_d;
  res_t       s1_res_q, s1_res_d, out_res_q, out_res_d;
  logic       s1_adv, s2_adv;

  always_comb begin
    s2_adv        = ~vld_pipe_q[2] | out_ready;
    s1_adv        = ~vld_pipe_q[1] | s2_adv;
    vld_pipe_d[1] = flush ? 1'b0 : (s1_adv ? in_valid : vld_pipe_q[1]);
    vld_pipe_d[2] = flush ? 1'b0 : (s2_adv ? vld_pipe_q[1] : vld_pipe_q[2]);
    s1_res_d      = s1_res_q;
    if (s1_adv && in_valid && !flush)
      s1_res_d = '{tag: in_tag, cnt: tree_cnt, zero: tree_zero};
    out_res_d     = out_res_q;
    if (s2_adv && vld_pipe_q[1])
      out_res_d = s1_res_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_res_q   <= '0;
      out_res_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_res_q   <= s1_res_d;
      out_res_q  <= out_res_d;
    end
  end

`ifdef LZC_NORM_EN
  logic [WIDTH-1:0] s1_op_q, s1_op_d, out_data_q, out_data_d;

  always_comb begin
    s1_op_d    = s1_op_q;
    if (s1_adv && in_valid && !flush)
      s1_op_d = in_data;
    out_data_d = out_data_q;
    if (s2_adv && vld_pipe_q[1])
      out_data_d = s1_op_q << s1_res_q.cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_op_q    <= '0;
      out_data_q <= '0;
    end else begin
      s1_op_q    <= s1_op_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;
`else
  assign out_data = '0;
`endif

  // Flush frees the front end immediately; the incoming beat is dropped.
  assign in_ready  = s1_adv | flush;
  assign out_valid = vld_pipe_q[2];
  assign out_count = out_res_q.cnt;
  assign out_zero  = out_res_q.zero;
  assign out_tag   = out_res_q.tag;

endmodule

// File: tb/tb_lzc_pipe.sv
// Randomised and directed bench for lzc_pipe against a scan-from-MSB reference model.
module tb_lzc_pipe;
  localparam int W  = 128;
  localparam int TW = 4;
  localparam int CW = 7;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [TW-1:0] in_tag, out_tag;
  logic [CW-1:0] out_count;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          zero;
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0, n_out = 0;

  lzc_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_zero(out_zero), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic [TW-1:0] t);
    exp_t e;
    int   lz = W;
    for (int i = W-1; i >= 0; i--)
      if (d[i]) begin lz = W-1-i; break; end
    e.zero = (d == '0);
    e.cnt  = e.zero ? '0 : CW'(lz);
    e.tag  = t;
`ifdef LZC_NORM_EN
    e.data = e.zero ? '0 : d << lz;
`else
    e.data = '0;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom % 16 == 0) return '0;
    return r >> $urandom_range(0, W-1);
  endfunction

  // Scoreboard: inputs are modelled at acceptance, outputs checked in order at consumption.
  logic          stall_p = 1'b0;
  logic [CW-1:0] cnt_p;
  logic          zero_p;
  logic [TW-1:0] tag_p;
  logic [W-1:0]  data_p;
  exp_t          e;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      stall_p <= 1'b0;
    end else begin
      if (stall_p && out_valid) begin
        chk("hold_count", W'(out_count), W'(cnt_p));
        chk("hold_zero",  W'(out_zero),  W'(zero_p));
        chk("hold_tag",   W'(out_tag),   W'(tag_p));
        chk("hold_data",  out_data,      data_p);
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          chk("q_nonempty", W'(q.size() != 0), W'(1));
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("count", W'(out_count), W'(e.cnt));
            chk("zero",  W'(out_zero),  W'(e.zero));
            chk("tag",   W'(out_tag),   W'(e.tag));
            chk("data",  out_data,      e.data);
            n_out++;
          end
        end
        if (in_valid && in_ready) q.push_back(model(in_data, in_tag));
      end
      stall_p <= out_valid && !out_ready;
      cnt_p   <= out_count;
      zero_p  <= out_zero;
      tag_p   <= out_tag;
      data_p  <= out_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pipe must be empty with out_ready=1; counts cycles from presentation to out_valid.
  task automatic lat_test(input logic [W-1:0] d, input logic [TW-1:0] t, input string nm);
    int lat = 0;
    in_valid = 1'b1; in_data = d; in_tag = t;
    do begin
      tick();
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    chk(nm, W'(lat), W'(2));
  endtask

  initial begin : main
    logic [15:0]  ov;
    logic [3:0]   ir;
    logic [W-1:0] d;
    int           acc, n0, seen;
    logic         took;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_tag = '0;
    #12;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_ready", W'(in_ready),  W'(1));
    chk("rst_count", W'(out_count), W'(0));
    chk("rst_zero",  W'(out_zero),  W'(0));
    chk("rst_tag",   W'(out_tag),   W'(0));
    chk("rst_data",  out_data,      W'(0));
    #10 reset = 1'b0;
    tick();

    lat_test(W'(1) << 64, 4'h3, "lat_bit64");
    tick(); tick();

    // Single-bit sweep, then zero and MSB-only.
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1; in_data = W'(1) << i; in_tag = i[3:0];
      tick();
    end
    in_data = '0; in_tag = 4'hE; tick();
    in_data = W'(1) << (W-1); in_tag = 4'hF; tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back: eight results on eight consecutive cycles.
    ov = '0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8); in_tag = c[3:0]; in_data = rnd();
      tick();
      ov[c] = out_valid;
    end
    chk("b2b_mask", W'(ov), W'(16'h01FE));

    // Backpressure: two accepts fill the pipe, then release.
    out_ready = 1'b0; acc = 0; d = rnd(); ir = '0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = d; in_tag = TW'(8 + acc);
      ir[c] = in_ready;
      if (in_ready) begin acc++; d = rnd(); end
      tick();
    end
    chk("bp_ready", W'(ir), W'(4'b0011));
    in_data = d; in_tag = 4'hA; out_ready = 1'b1; n0 = n_out;
    #1 chk("bp_ready_rel", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_delivered", W'(n_out - n0), W'(3));

    // Flush with both stages full plus a new beat.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rnd(); in_tag = 4'h1; tick();
    in_data = rnd(); in_tag = 4'h2; tick();
    in_data = rnd(); in_tag = 4'h3; flush = 1'b1;
    #1 chk("flush_ready", W'(in_ready), W'(1));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ov", W'(out_valid), W'(0));
    out_ready = 1'b1; seen = 0;
    repeat (3) begin tick(); seen = seen | int'(out_valid); end
    chk("flush_empty", W'(seen), W'(0));
    lat_test(rnd(), 4'h5, "lat_flush");
    tick(); tick();

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = rnd(); in_tag = c[3:0];
      tick();
    end
    chk("pre_rst_ov", W'(out_valid), W'(1));
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_ov",    W'(out_valid), W'(0));
    chk("arst_ready", W'(in_ready),  W'(1));
    chk("arst_count", W'(out_count), W'(0));
    #10 reset = 1'b0;
    tick();
    lat_test(W'(16'h0F00) << (W-16), 4'hA, "lat_rst");
    tick(); tick();

    // Random traffic with random backpressure and occasional flush.
    took = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom % 4 != 0);
        in_data  = rnd();
        in_tag   = TW'($urandom);
      end
      out_ready = ($urandom % 3 != 0);
      flush     = ($urandom % 64 == 0);
      #1 took = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("drain", W'(q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
